// File: rtl/addsub_rr_scheduler.sv
// -----------------------------------------------------------------------------
// addsub_rr_scheduler
//
// Shares one external add/sub unit among NUM_REQ requesters. One operation is
// in flight at a time: a round-robin grant in IDLE latches the winner's
// operands onto alu_in*, the unit's fixed latency is timed with a down-counter,
// and the captured result is returned with the requester index on a
// valid/ready response port.
//
// Parameters
//   NUM_REQ  number of requesters (2..16)
//   WIDTH    operand width
//   LAT      shared unit latency in cycles (0 = combinational, up to 15)
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (ready is one-hot or 0)
//   req_in1/req_in2/req_sub   packed per-requester operands and op select
//   alu_in1/alu_in2/alu_sub   operands driven to the shared unit
//   alu_out                   shared unit result (WIDTH+1 bits)
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_data           owning requester and captured result
//   op_count                  completed-response counter (ADDSUB_SCHED_STATS_EN)
//
// Optional feature macro: ADDSUB_SCHED_STATS_EN adds the saturating 16-bit
// op_count output.
//
// State table
//   IDLE | waiting for a request; grants one requester round-robin
//   EXEC | operands held on alu_in*, counting down the unit latency
//   RESP | result presented on rsp_*, waiting for rsp_ready
// -----------------------------------------------------------------------------
module addsub_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LAT     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
    input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
    input  logic [NUM_REQ-1:0]         req_sub,
    output logic [WIDTH-1:0]           alu_in1,
    output logic [WIDTH-1:0]           alu_in2,
    output logic                       alu_sub,
    input  logic [WIDTH:0]             alu_out,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
`ifdef ADDSUB_SCHED_STATS_EN
    output logic [15:0]                op_count,
`endif
    output logic [WIDTH:0]             rsp_data
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [3:0]       count_q, count_d;
    logic [IW-1:0]    id_q, id_d;
    logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
    logic             alu_sub_q, alu_sub_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IW-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH:0]   rsp_data_q, rsp_data_d;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    logic [IW-1:0] grant;
    logic          grant_vld;
    logic [IW:0]   scan;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan >= (IW+1)'(NUM_REQ)) begin
                scan = scan - (IW+1)'(NUM_REQ);
            end
            if (!grant_vld && req_valid[scan[IW-1:0]]) begin
                grant     = scan[IW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    logic resp_done;
    assign resp_done = (state_q == S_RESP) && rsp_ready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        count_d     = count_q;
        id_d        = id_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_sub_d   = alu_sub_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        req_ready   = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    // Gated by rst so no requester sees an accept that the
                    // reset is about to throw away.
                    req_ready[grant] = !rst;
                    alu_in1_d = req_in1[grant*WIDTH +: WIDTH];
                    alu_in2_d = req_in2[grant*WIDTH +: WIDTH];
                    alu_sub_d = req_sub[grant];
                    id_d      = grant;
                    rr_ptr_d  = (grant == IW'(NUM_REQ-1)) ? '0 : grant + 1'b1;
                    count_d   = 4'(LAT);
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    rsp_data_d  = alu_out;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            count_q     <= '0;
            id_q        <= '0;
            alu_in1_q   <= '0;
            alu_in2_q   <= '0;
            alu_sub_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            count_q     <= count_d;
            id_q        <= id_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_sub_q   <= alu_sub_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign alu_in1   = alu_in1_q;
    assign alu_in2   = alu_in2_q;
    assign alu_sub   = alu_sub_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef ADDSUB_SCHED_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (resp_done && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`else
    logic unused_resp_done;
    assign unused_resp_done = resp_done;
`endif

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
module tb_addsub_rr_scheduler;

    localparam int N      = 4;
    localparam int W      = 8;
    localparam int TB_LAT = 1;
    localparam int IW     = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_in1;
    logic [N*W-1:0] req_in2;
    logic [N-1:0]   req_sub;
    logic [W-1:0]   alu_in1;
    logic [W-1:0]   alu_in2;
    logic           alu_sub;
    logic [W:0]     alu_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W:0]     rsp_data;
`ifdef ADDSUB_SCHED_STATS_EN
    logic [15:0]    op_count;
`endif

    always #5 clk = ~clk;

    addsub_rr_scheduler #(
        .NUM_REQ(N),
        .WIDTH  (W),
        .LAT    (TB_LAT)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_in1  (req_in1),
        .req_in2  (req_in2),
        .req_sub  (req_sub),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .alu_sub  (alu_sub),
        .alu_out  (alu_out),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
`ifdef ADDSUB_SCHED_STATS_EN
        .op_count (op_count),
`endif
        .rsp_data (rsp_data)
    );

    // Shared add/sub unit with TB_LAT cycles of pipeline delay.
    logic [W:0] alu_comb;
    logic [W:0] alu_pipe [0:15];
    assign alu_comb = alu_sub ? ({1'b0, alu_in1} - {1'b0, alu_in2})
                              : ({1'b0, alu_in1} + {1'b0, alu_in2});
    always @(posedge clk) begin
        alu_pipe[0] <= alu_comb;
        for (int i = 1; i < 16; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_out = (TB_LAT == 0) ? alu_comb : alu_pipe[(TB_LAT == 0) ? 0 : TB_LAT-1];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: one op outstanding, response due
    // 2+LAT cycles after acceptance, round-robin pointer after the winner.
    int          cyc        = 0;
    bit          m_init     = 0;
    bit          m_busy     = 0;
    int          m_rsp_from = 0;
    int          m_ptr      = 0;
    int          m_id       = 0;
    logic [W:0]  m_data     = '0;
    logic [W-1:0] m_alu1    = '0;
    logic [W-1:0] m_alu2    = '0;
    logic        m_alusub   = 1'b0;
    int          m_ops      = 0;

    logic [N-1:0]  s_req_ready;
    logic          s_rsp_valid;
    logic [IW-1:0] s_rsp_id;
    logic [W:0]    s_rsp_data;
    logic [W-1:0]  s_alu_in1;
    logic [15:0]   s_op_count = '0;

    task automatic tick();
        logic [N-1:0] exp_ready;
        logic         exp_rsp;
        int           g;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        @(negedge clk);
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_id    = rsp_id;
        s_rsp_data  = rsp_data;
        s_alu_in1   = alu_in1;
`ifdef ADDSUB_SCHED_STATS_EN
        s_op_count  = op_count;
`endif
        exp_ready = '0;
        g = -1;
        if (!rst && !m_busy && (req_valid != '0)) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_ready[g] = 1'b1;
        end
        exp_rsp = m_busy && (cyc >= m_rsp_from);
        check_eq("req_ready", req_ready, exp_ready);
        if (m_init) begin
            check_eq("rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp) begin
                check_eq("rsp_id", rsp_id, m_id);
                check_eq("rsp_data", rsp_data, m_data);
            end
            check_eq("alu_in1", alu_in1, m_alu1);
            check_eq("alu_in2", alu_in2, m_alu2);
            check_eq("alu_sub", alu_sub, m_alusub);
`ifdef ADDSUB_SCHED_STATS_EN
            check_eq("op_count", op_count, m_ops);
`endif
        end
        if (rst) begin
            m_init = 1; m_busy = 0; m_ptr = 0; m_ops = 0;
            m_alu1 = '0; m_alu2 = '0; m_alusub = 1'b0;
        end else if (exp_rsp && rsp_ready) begin
            m_busy = 0;
            if (m_ops != 65535) m_ops++;
        end else if (g >= 0) begin
            a = req_in1[g*W +: W];
            b = req_in2[g*W +: W];
            s = req_sub[g];
            m_busy     = 1;
            m_rsp_from = cyc + 2 + TB_LAT;
            m_ptr      = (g + 1) % N;
            m_id       = g;
            m_data     = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
            m_alu1     = a;
            m_alu2     = b;
            m_alusub   = s;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        req_in1[i*W +: W] = a;
        req_in2[i*W +: W] = b;
        req_sub[i]        = s;
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic wait_rsp(input int max_cyc);
        int n;
        n = 0;
        s_rsp_valid = 1'b0;
        while (!s_rsp_valid && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("wait_rsp_in_time", s_rsp_valid, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (m_busy && n < 40) begin
            tick();
            n++;
        end
        check_eq("drain_in_time", m_busy, 1'b0);
    endtask

    int grants_q[$];

    task automatic collect_grants(input int n_want);
        int n;
        n = 0;
        grants_q.delete();
        while (grants_q.size() < n_want && n < n_want*(TB_LAT+3) + 10) begin
            tick();
            if (s_req_ready != '0) grants_q.push_back(onehot_idx(s_req_ready));
            n++;
        end
        check_eq("grant_count", grants_q.size(), n_want);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_rr1 [6];
        int exp_rr2 [4];
        logic [IW-1:0] id0;
        logic [W:0]    data0;
        exp_rr1 = '{0, 1, 2, 3, 0, 1};
        exp_rr2 = '{1, 3, 1, 3};

        rst       = 1'b1;
        req_valid = {N{1'b1}};
        req_in1   = '0;
        req_in2   = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        // Reset held two cycles with every request valid.
        tick();
        check_eq("rst_req_ready_c0", s_req_ready, 0);
        tick();
        check_eq("rst_req_ready_c1", s_req_ready, 0);
        check_eq("rst_rsp_valid", s_rsp_valid, 0);
        check_eq("rst_rsp_data", s_rsp_data, 0);
        check_eq("rst_alu_in1", s_alu_in1, 0);

        // First post-reset cycle: single add from requester 0.
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom), 1'($urandom));
        set_op(0, 8'h0F, 8'h01, 1'b0);
        tick();
        check_eq("post_rst_rsp_data", s_rsp_data, 0);
        check_eq("post_rst_alu_in1", s_alu_in1, 0);
        check_eq("first_grant_req0", s_req_ready, 4'b0001);
        req_valid = '0;
        tick();
        check_eq("add_alu_in1", s_alu_in1, 8'h0F);
        repeat (TB_LAT) begin
            tick();
            check_eq("add_rsp_not_early", s_rsp_valid, 0);
        end
        tick();
        check_eq("add_rsp_valid", s_rsp_valid, 1);
        check_eq("add_rsp_id", s_rsp_id, 0);
        check_eq("add_rsp_data", s_rsp_data, 9'h010);
        tick();

        // Subtract with borrow from requester 2.
        req_valid = 4'b0100;
        set_op(2, 8'h05, 8'h07, 1'b1);
        tick();
        check_eq("sub_grant_req2", s_req_ready, 4'b0100);
        req_valid = '0;
        wait_rsp(10);
        check_eq("sub_rsp_id", s_rsp_id, 2);
        check_eq("sub_rsp_data", s_rsp_data, 9'h1FE);
        tick();

        // Round robin over all requesters from a fresh pointer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        collect_grants(6);
        for (int i = 0; i < 6; i++)
            if (i < grants_q.size()) check_eq($sformatf("rr_all_%0d", i), grants_q[i], exp_rr1[i]);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1010;
        collect_grants(4);
        for (int i = 0; i < 4; i++)
            if (i < grants_q.size()) check_eq($sformatf("rr_odd_%0d", i), grants_q[i], exp_rr2[i]);

        // Backpressure: response held for 5 cycles, requests stay blocked.
        wait_idle();
        set_op(0, 8'hC3, 8'h5A, 1'b0);
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        tick();
        check_eq("bp_grant_req0", s_req_ready, 4'b0001);
        wait_rsp(10);
        id0   = s_rsp_id;
        data0 = s_rsp_data;
        check_eq("bp_rsp_id", id0, 0);
        check_eq("bp_rsp_data", data0, 9'h11D);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("bp_hold_valid", s_rsp_valid, 1);
            check_eq("bp_hold_id", s_rsp_id, id0);
            check_eq("bp_hold_data", s_rsp_data, data0);
            check_eq("bp_req_blocked", s_req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("bp_handshake_no_grant", s_req_ready, 0);
        tick();
        check_eq("bp_next_grant", s_req_ready, 4'b0010);

        // Reset on the second EXEC cycle aborts the op silently.
        req_valid = '0;
        tick();
`ifdef ADDSUB_SCHED_STATS_EN
        check_eq("ops_before_abort", s_op_count, m_ops);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1010;
        tick();
        check_eq("abort_no_rsp", s_rsp_valid, 0);
        check_eq("abort_next_grant", s_req_ready, 4'b0010);
`ifdef ADDSUB_SCHED_STATS_EN
        check_eq("abort_op_count", s_op_count, 0);
`endif

        // Randomised traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 1) == 0) ? N'($urandom) : (N'($urandom) & N'($urandom));
            for (int i = 0; i < N; i++) set_op(i, W'($urandom), W'($urandom), 1'($urandom));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
- Round-robin scheduler that shares one external adder/subtractor datapath among NUM_REQ requesters.
- Accepts one operation at a time from a valid/ready request port and drives the shared unit's operand inputs.
- Waits the unit's fixed latency, then returns the result tagged with the requester index on a valid/ready response port.
- Sits between the client blocks and the single add/sub instance in the arithmetic subsystem.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- WIDTH, 8, operand width.
- LAT, 1, shared unit latency in cycles from alu_in* stable to alu_out valid; 0 means combinational; legal range 0..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_in1  input  NUM_REQ*WIDTH  operand 1; requester i occupies bits [i*WIDTH +: WIDTH].
- req_in2  input  NUM_REQ*WIDTH  operand 2; same packing as req_in1.
- req_sub  input  NUM_REQ  per-requester op select; 1 = in1-in2, 0 = in1+in2.
- alu_in1  output  WIDTH  operand 1 to shared unit.
- alu_in2  output  WIDTH  operand 2 to shared unit.
- alu_sub  output  1  op select to shared unit.
- alu_out  input  WIDTH+1  shared unit result; bit WIDTH is carry (add) or borrow/sign (sub), two's complement.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  $clog2(NUM_REQ)  index of requester owning rsp_data.
- rsp_data  output  WIDTH+1  captured alu_out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, count=0.
  - req_ready=0, alu_in1/alu_in2/alu_sub=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - Reset mid-operation discards the in-flight op; no response is ever issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant g = first index with req_valid high, searching from rr_ptr upward and wrapping NUM_REQ-1 -> 0.
  - req_ready[g]=1 combinationally in this cycle only.
  - At the edge: latch req_in1/req_in2/req_sub of g into alu_in1/alu_in2/alu_sub; id<=g; rr_ptr<=(g+1) mod NUM_REQ; count<=LAT; state<=EXEC.
  - If no req_valid is high: stay in IDLE, rr_ptr unchanged.
- EXEC:
  - alu_in* are held stable.
  - If count!=0: count<=count-1.
  - If count==0: rsp_data<=alu_out, rsp_id<=id, rsp_valid<=1, state<=RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, state<=IDLE.
  - No request is accepted during RESP.
- Timing:
  - Acceptance cycle T.
  - rsp_valid first high in cycle T+2+LAT.
  - Minimum issue interval with rsp_ready=1 is LAT+3 cycles.
- req_ready is 0 in EXEC and RESP.
- req_* inputs are sampled only in IDLE; dropping req_valid before a grant is legal and carries no penalty.
- Fairness: a requester holding req_valid is granted within NUM_REQ grants.
- alu_in* keep the last operands after completion; no return to 0 except on reset.

Optional Feature:
- Macro: ADDSUB_SCHED_STATS_EN.
- Defined: adds output port op_count (16 bits).
  - Reset to 0.
  - Increments by 1 on each rsp_valid&&rsp_ready handshake.
  - Saturates at 16'hFFFF.
  - Not cleared by anything but rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 2 cycles with req_valid=4'hF -> req_ready=0, rsp_valid=0, alu_in1/alu_in2/alu_sub=0, rsp_data=0 during reset and on the first post-reset cycle; first grant goes to requester 0.
- Single add, LAT=1: req0 in1=8'h0F, in2=8'h01, sub=0 accepted at T -> alu_in1=8'h0F from T+1; rsp_valid at T+3 with rsp_id=0, rsp_data=9'h010.
- Subtract with borrow: req2 in1=8'h05, in2=8'h07, sub=1 -> rsp_id=2, rsp_data=9'h1FE.
- Round robin: req_valid=4'hF held, rsp_ready=1 -> grant order 0,1,2,3,0,1; with only req1 and req3 valid, order alternates 1,3,1,3.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid, rsp_id and rsp_data stable; req_ready stays 0; single-cycle rsp_ready then returns to IDLE and the next grant occurs one cycle later.
- Reset mid-EXEC (LAT=3): rst pulsed on 2nd EXEC cycle -> no rsp_valid for that op; rr_ptr=0, so with req1 and req3 valid the next grant is 1. With ADDSUB_SCHED_STATS_EN defined, op_count is unchanged by the aborted op and reads 0 after reset.
